// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, control-bundle layout and state encoding for pipeline stages
package pipe_pkg;

    // Control bundle layout
    localparam int CF_S_MXSE     = 0;
    localparam int CF_OP_ALU_LSB = 1;
    localparam int CF_OP_ALU_MSB = 5;
    localparam int CF_W_DM       = 6;
    localparam int CF_S_MXRB_LSB = 7;
    localparam int CF_S_MXRB_MSB = 8;
    localparam int CF_W_RB       = 9;
    localparam int CF_W_RF_LSB   = 10;
    localparam int CF_W_RF_MSB   = 12;

    localparam int PIPE_CTRL_W = 13;

    // ALU opcode that passes operand B through unchanged
    localparam logic [4:0] OP_PASSB = 5'b10011;

    // Bubble bundle: no RF/RB/DM writes, ALU passb, S_MXSE=1
    localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = 13'h027;

    // Encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// rtl/pipe_skid_ctrl.sv - handshake state machine for the skid-buffered pipeline stage
//
// Ports:
//   CLK, RESET     clock (rising) and asynchronous active-high reset
//   in_valid       upstream word valid
//   out_ready      downstream accepts
//   flush          synchronous kill of all held entries
//   in_ready       registered accept indication (low only while both entries held)
//   out_valid      main register holds a valid entry
//   load_main      main register loads this edge
//   main_sel_skid  main loads from skid (1) or from input (0)
//   load_skid      skid register captures the input this edge
//   to_empty       stage becomes empty this edge; main ctrl is forced to the bubble value
//   occupancy      entries held (0..2)
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_valid,
    input  logic       out_ready,
    input  logic       flush,
    output logic       in_ready,
    output logic       out_valid,
    output logic       load_main,
    output logic       main_sel_skid,
    output logic       load_skid,
    output logic       to_empty,
    output logic [1:0] occupancy
);

    pipe_state_t state;
    pipe_state_t state_nxt;
    logic        acc;
    logic        take;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            // Registered from the next state so it never sees out_ready combinationally
            in_ready <= (state_nxt != ST_SKID);
        end
    end

    always_comb begin
        state_nxt     = state;
        load_main     = 1'b0;
        main_sel_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    load_main = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (take && acc) begin
                    load_main = 1'b1;
                end else if (take) begin
                    state_nxt = ST_EMPTY;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_nxt = ST_SKID;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so no input can be accepted
                if (take) begin
                    load_main     = 1'b1;
                    main_sel_skid = 1'b1;
                    state_nxt     = ST_FULL;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        // Flush beats any simultaneous accept; the data registers simply hold
        if (flush) begin
            state_nxt     = ST_EMPTY;
            load_main     = 1'b0;
            main_sel_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    assign to_empty = (state_nxt == ST_EMPTY);

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with valid/ready handshake and 2-entry skid
//
// Ports:
//   CLK, RESET          clock (rising) and asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is registered
//   in_data             NCH words of DATA_W, word k at [k*DATA_W +: DATA_W]
//   in_ctrl             control bundle
//   flush               synchronous kill of all held entries
//   out_valid/out_ready downstream handshake
//   out_data, out_ctrl  main register contents; out_ctrl is NOP_CTRL whenever out_valid=0
//   occupancy           entries held (0..2)
//   bubble_cnt          saturating count of cycles with out_valid=0
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NCH      = 3,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL = PIPE_NOP_CTRL,
    parameter int                CNT_W    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic                  load_main;
    logic                  main_sel_skid;
    logic                  load_skid;
    logic                  to_empty;
    logic [NCH*DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0]     skid_ctrl;

    pipe_skid_ctrl u_ctrl (
        .CLK           (CLK),
        .RESET         (RESET),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .flush         (flush),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .load_main     (load_main),
        .main_sel_skid (main_sel_skid),
        .load_skid     (load_skid),
        .to_empty      (to_empty),
        .occupancy     (occupancy)
    );

    // Main register: drives the outputs directly
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_data <= '0;
            out_ctrl <= NOP_CTRL;
        end else if (load_main) begin
            out_data <= main_sel_skid ? skid_data : in_data;
            out_ctrl <= main_sel_skid ? skid_ctrl : in_ctrl;
        end else if (to_empty) begin
            // Data is left alone; only the bundle is neutralised so a bubble can't write
            out_ctrl <= NOP_CTRL;
        end
    end

    // Skid register: holds the word accepted while downstream stalled
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and scoreboard checks for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int NCH    = 3;
    localparam int CTRL_W = 13;
    localparam logic [CTRL_W-1:0] NOP = 13'h027;

    logic                  CLK;
    logic                  RESET;
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH*DATA_W-1:0] in_data;
    logic [CTRL_W-1:0]     in_ctrl;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]     out_ctrl;
    logic [1:0]            occupancy;
    logic [15:0]           bubble_cnt;

    logic                  s_in_ready;
    logic                  s_out_valid;
    logic [NCH*DATA_W-1:0] s_out_data;
    logic [CTRL_W-1:0]     s_out_ctrl;
    logic [1:0]            s_occupancy;
    logic [1:0]            s_bubble_cnt;

    int n_vec;
    int n_err;

    pipe_stage_skid #(.DATA_W(DATA_W), .NCH(NCH), .CTRL_W(CTRL_W), .NOP_CTRL(NOP), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .NCH(NCH), .CTRL_W(CTRL_W), .NOP_CTRL(NOP), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [NCH*DATA_W-1:0] word(input logic [31:0] v);
        return {v ^ 32'hCCCC_0000, v ^ 32'hBBBB_0000, v};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Load A then B with downstream stalled, leaving both entries held
    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word(a);
        in_ctrl   = 13'h100;
        tick();
        in_data   = word(b);
        in_ctrl   = 13'h200;
        tick();
        in_valid  = 1'b0;
    endtask

    typedef struct {
        logic [NCH*DATA_W-1:0] d;
        logic [CTRL_W-1:0]     c;
    } ent_t;

    ent_t sb[$];
    ent_t e;

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset values and idle bubble counting
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, NOP);
        chk("rst_bubble", bubble_cnt, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("idle_ctrl_nop", out_ctrl, NOP);
            if (i == 5) chk("bubble_5", bubble_cnt, 5);
        end
        chk("bubble_6", bubble_cnt, 6);
        chk("bubble_sat", s_bubble_cnt, 3);

        // Streaming: four words back-to-back with out_ready=1
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = word(32'h11 * i);
            in_ctrl = 13'(13'h040 + i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, word(32'h11 * i));
            chk("stream_ctrl", out_ctrl, 13'(13'h040 + i));
            chk("stream_occ", occupancy, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_drain_ctrl", out_ctrl, NOP);
        chk("stream_drain_occ", occupancy, 0);

        // Skid: A held, B goes to skid, then both drain in order
        fill_two(32'hA, 32'hB);
        chk("skid_occ", occupancy, 2);
        chk("skid_in_ready", in_ready, 0);
        chk("skid_main_A", out_data, word(32'hA));
        chk("skid_ctrl_A", out_ctrl, 13'h100);
        out_ready = 1'b1;
        tick();
        chk("skid_out_B", out_data, word(32'hB));
        chk("skid_ctrl_B", out_ctrl, 13'h200);
        chk("skid_occ_1", occupancy, 1);
        chk("skid_in_ready_1", in_ready, 1);
        tick();
        chk("skid_empty_valid", out_valid, 0);
        chk("skid_empty_ctrl", out_ctrl, NOP);

        // Flush with both entries held and an input word C offered
        fill_two(32'hA2, 32'hB2);
        chk("flush_pre_occ", occupancy, 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = word(32'hC);
        in_ctrl  = 13'h300;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, NOP);
        chk("flush_occ", occupancy, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_data_held", out_data, word(32'hA2));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_C", out_valid, 0);
        end

        // Asynchronous reset while both entries held
        fill_two(32'hD1, 32'hD2);
        chk("areset_pre_occ", occupancy, 2);
        #2;
        RESET = 1'b1;
        #1;
        chk("areset_valid", out_valid, 0);
        chk("areset_occ", occupancy, 0);
        chk("areset_in_ready", in_ready, 1);
        chk("areset_data", out_data, 0);
        chk("areset_ctrl", out_ctrl, NOP);
        chk("areset_bubble", bubble_cnt, 0);
        tick();
        RESET = 1'b0;

        // Random handshake traffic against a scoreboard FIFO
        sb.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic rd;
            chk("rnd_occ", occupancy, 128'(sb.size()));
            chk("rnd_valid", out_valid, (sb.size() != 0));
            chk("rnd_in_ready", in_ready, (sb.size() != 2));
            if (sb.size() != 0) begin
                chk("rnd_data", out_data, sb[0].d);
                chk("rnd_ctrl", out_ctrl, sb[0].c);
            end else begin
                chk("rnd_nop", out_ctrl, NOP);
            end
            rd        = in_ready;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = 13'($urandom);
            #1;
            chk("rnd_in_ready_stable", in_ready, rd);
            if (out_valid && out_ready) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                e.d = in_data;
                e.c = in_ctrl;
                sb.push_back(e);
            end
            @(posedge CLK);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Carries NCH datapath words plus one control bundle between pipeline stages (e.g. ID->EX, EX->MEM).
- Adds synchronous flush, guaranteed NOP-bubble control output when empty, and a saturating bubble counter.
- Replaces the fixed-field, enable-only stage registers in the processor pipeline.

Parameters:
- DATA_W, 32, width of one datapath word.
- NCH, 3, number of datapath words carried (default: PC, PRA, PRB).
- CTRL_W, 13, control bundle width.
- NOP_CTRL, 13'h027, bundle value for a bubble: {W_RF=000, W_RB=0, S_MXRB=00, W_DM=0, OP_ALU=10011 (passb), S_MXSE=1}.
- CNT_W, 16, bubble counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  NCH*DATA_W  payload; word k is in bits [k*DATA_W +: DATA_W].
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NCH*DATA_W  payload.
- out_ctrl  out  CTRL_W  control bundle; NOP_CTRL whenever out_valid=0.
- occupancy  out  2  entries held (0..2).
- bubble_cnt  out  CNT_W  cycles with out_valid=0; saturates.

Behaviour:
- Reset is asynchronous, active-high, and has effect immediately with no clock edge.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=NOP_CTRL, occupancy=0, bubble_cnt=0, skid register=0.
- Reset mid-transfer drops both entries with no partial output.
- Handshake terms:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
- Datapath registers:
  - Main register drives out_*.
  - Skid register is internal.
- States, with occupancy equal to 0/1/2:
  - EMPTY:
    - acc loads main; next state FULL.
  - FULL:
    - take & acc: main reloads; stay FULL.
    - take & !acc: -> EMPTY.
    - !take & acc: input goes to skid; -> SKID.
    - !take & !acc: hold.
  - SKID:
    - in_ready=0, so acc is impossible.
    - take: skid moves to main; -> FULL.
    - !take: hold.
- in_ready = (next state != SKID), registered. It never depends combinationally on out_ready.
- Latency: 1 cycle in->out when EMPTY.
- Sustained throughput: 1 transfer/cycle with out_ready=1.
- Ordering is strict FIFO. The skid entry never overtakes main.
- Flush:
  - Next state EMPTY, out_valid=0, out_ctrl=NOP_CTRL, in_ready=1.
  - out_data and skid data are held, not cleared.
  - Flush wins over a simultaneous acc; that input word is discarded.
  - A take in the flush cycle still completes downstream, since out was valid that cycle.
- out_ctrl is forced to NOP_CTRL on every transition to out_valid=0. This guarantees no register-file or memory writes from a bubble.
- bubble_cnt:
  - Increments each clock edge where out_valid=0 (sampled pre-edge).
  - Holds at 2^CNT_W-1.
  - Cleared only by RESET.
- No X propagation: all registers have reset values. Payload width is exactly NCH*DATA_W with no padding.

Decomposition:
- Package pipe_pkg holds:
  - Control-bundle field offsets: S_MXSE=0, OP_ALU=[5:1], W_DM=6, S_MXRB=[8:7], W_RB=9, W_RF=[12:10].
  - CTRL_W=13 and NOP_CTRL=13'h027.
  - ALU opcode constant OP_PASSB=5'b10011.
  - State encoding ST_EMPTY/ST_FULL/ST_SKID.
- One natural sub-module: pipe_skid_ctrl, holding the state machine, in_ready, load/select enables and occupancy. The top instantiates it plus the main and skid data registers and bubble_cnt.

Test Plan:
1. Reset, then stream 4 words data=0x11..0x44 with out_ready=1 -> each word appears 1 cycle later, 4 consecutive out_valid cycles, occupancy never exceeds 1.
2. Load A=0xA, hold out_ready=0, present B=0xB -> occupancy=2, in_ready=0 next cycle. Release out_ready -> A then B out on consecutive cycles, in_ready=1 after A taken.
3. occupancy=2, assert flush with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=13'h027, occupancy=0; C never appears.
4. Assert RESET asynchronously mid-cycle while occupancy=2 -> outputs reach reset values before the next CLK edge.
5. Hold in_valid=0 for 5 cycles after reset -> bubble_cnt=5, out_ctrl=13'h027 throughout. With CNT_W=2 and 6 idle cycles -> bubble_cnt=3 (saturated).
6. Random in_valid/out_ready for 10k cycles against a scoreboard FIFO -> no loss, duplication or reordering, and in_ready never toggles combinationally with out_ready.
